// File: rtl/sipo_packer_pkg.sv
// Shared widths, the FIFO entry type and the flush padding helper
// used by the byte packer and its word FIFO.
package sipo_packer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [1:0]        nbytes;
    } fifo_entry_t;

    // Left-align the k most recent held bytes (k = 1..3) and fill the rest with pad.
    function automatic logic [WORD_W-1:0] pad_word(input logic [23:0]       held,
                                                   input logic [1:0]        k,
                                                   input logic [BYTE_W-1:0] pad);
        case (k)
            2'd1:    return {held[7:0], pad, pad, pad};
            2'd2:    return {held[15:0], pad, pad};
            default: return {held, pad};
        endcase
    endfunction

endpackage

// File: rtl/sipo_packer_if.sv
// Byte-stream input, flush and word read port of the SIPO packer.
interface sipo_packer_if #(parameter int DEPTH_PWR = 4);
    import sipo_packer_pkg::*;

    logic [BYTE_W-1:0] din;
    logic              din_valid;
    logic              flush;
    logic [WORD_W-1:0] dout;
    logic [1:0]        dout_nbytes;
    logic              dout_valid;
    logic              dout_ready;
    logic [DEPTH_PWR:0] level;
    logic              overflow;

    modport master (
        output din, din_valid, flush, dout_ready,
        input  dout, dout_nbytes, dout_valid, level, overflow
    );

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output dout, dout_nbytes, dout_valid, level, overflow
    );

endinterface

// File: rtl/sipo_packer_word_fifo.sv
// Circular word FIFO: pushes into a full FIFO are dropped and latch a
// sticky overflow flag; a same-cycle pop never makes room for the push.
module word_fifo
    import sipo_packer_pkg::*;
#(
    parameter int DEPTH_PWR = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  fifo_entry_t        entry_i,
    input  logic               pop_ready_i,
    output fifo_entry_t        head_o,
    output logic               valid_o,
    output logic [DEPTH_PWR:0] level_o,
    output logic               overflow_o
);

    localparam int DEPTH = 1 << DEPTH_PWR;

    fifo_entry_t        mem_q [DEPTH];
    logic [DEPTH_PWR:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_PWR:0] rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic               empty, full, do_write, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_PWR-1:0] == rd_ptr_q[DEPTH_PWR-1:0]) &&
                   (wr_ptr_q[DEPTH_PWR] != rd_ptr_q[DEPTH_PWR]);

    always_comb begin
        do_write   = push_i & ~full;
        do_pop     = pop_ready_i & ~empty;
        wr_ptr_d   = wr_ptr_q + {{DEPTH_PWR{1'b0}}, do_write};
        rd_ptr_d   = rd_ptr_q + {{DEPTH_PWR{1'b0}}, do_pop};
        overflow_d = overflow_q | (push_i & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[DEPTH_PWR-1:0]] <= entry_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q[DEPTH_PWR-1:0]];
    assign valid_o    = ~empty;
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/sipo_packer.sv
// Packs an MSB-first byte stream into 32-bit words, with flush closing a
// partial word using PAD_BYTE, and queues the words in a word_fifo.
module sipo_packer
    import sipo_packer_pkg::*;
#(
    parameter int                DEPTH_PWR = 4,
    parameter logic [BYTE_W-1:0] PAD_BYTE  = 8'h00
) (
    input  logic clk,
    input  logic rst,
    sipo_packer_if.slave bus
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] sr_q, sr_d;
    logic        push;
    fifo_entry_t push_entry;
    fifo_entry_t head;

    // The incoming byte is accounted for first, so flush sees the updated count.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        sr_d       = sr_q;
        push       = 1'b0;
        push_entry = '0;
        if (bus.din_valid) begin
            if (byte_cnt_q == 2'd3) begin
                push              = 1'b1;
                push_entry.word   = {sr_q, bus.din};
                push_entry.nbytes = 2'd3;
                byte_cnt_d        = 2'd0;
            end else begin
                sr_d       = {sr_q[15:0], bus.din};
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
        if (bus.flush && !push && byte_cnt_d != 2'd0) begin
            push              = 1'b1;
            push_entry.word   = pad_word(sr_d, byte_cnt_d, PAD_BYTE);
            push_entry.nbytes = byte_cnt_d - 2'd1;
            byte_cnt_d        = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            sr_q       <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            sr_q       <= sr_d;
        end
    end

    word_fifo #(
        .DEPTH_PWR (DEPTH_PWR)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .entry_i     (push_entry),
        .pop_ready_i (bus.dout_ready),
        .head_o      (head),
        .valid_o     (bus.dout_valid),
        .level_o     (bus.level),
        .overflow_o  (bus.overflow)
    );

    assign bus.dout        = head.word;
    assign bus.dout_nbytes = head.nbytes;

endmodule

// File: tb/tb_sipo_packer.sv
// Checks sipo_packer against a queue-based model of packing, flush and the
// drop-when-full FIFO, plus directed scenarios with literal expectations.
module tb_sipo_packer;

    localparam int         DP    = 4;
    localparam int         DEPTH = 1 << DP;
    localparam logic [7:0] PAD   = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_packer_if #(.DEPTH_PWR(DP)) bus ();

    sipo_packer #(.DEPTH_PWR(DP), .PAD_BYTE(PAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          cmpEn       = 1'b0;

    logic [7:0]  heldBytes[$];
    logic [33:0] modelFifo[$];
    bit          modelOvf = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] packHeld();
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[31-8*i -: 8] = (i < heldBytes.size()) ? heldBytes[i] : PAD;
        return w;
    endfunction

    function automatic void modelReset();
        heldBytes.delete();
        modelFifo.delete();
        modelOvf = 1'b0;
    endfunction

    function automatic void modelStep(input bit v, input logic [7:0] d, input bit f, input bit r);
        int          pre    = modelFifo.size();
        bit          doPush = 1'b0;
        logic [33:0] e      = '0;
        if (v) begin
            heldBytes.push_back(d);
            if (heldBytes.size() == 4) begin
                e      = {packHeld(), 2'd3};
                doPush = 1'b1;
                heldBytes.delete();
            end
        end
        if (f && !doPush && heldBytes.size() > 0) begin
            e      = {packHeld(), 2'(heldBytes.size() - 1)};
            doPush = 1'b1;
            heldBytes.delete();
        end
        if (r && pre > 0) void'(modelFifo.pop_front());
        if (doPush) begin
            if (pre == DEPTH) modelOvf = 1'b1;
            else modelFifo.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (cmpEn && !rst) begin
            checkOutput("dout_valid", 64'(bus.dout_valid), 64'(modelFifo.size() != 0));
            checkOutput("level", 64'(bus.level), 64'(modelFifo.size()));
            checkOutput("overflow", 64'(bus.overflow), 64'(modelOvf));
            if (modelFifo.size() != 0)
                checkOutput("head", 64'({bus.dout, bus.dout_nbytes}), 64'(modelFifo[0]));
        end
    end

    // One clock of stimulus; returns just after the following falling edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r);
        bus.din_valid  = v;
        bus.din        = d;
        bus.flush      = f;
        bus.dout_ready = r;
        @(posedge clk);
        if (!rst) modelStep(v, d, f, r);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit r);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, w[31-8*i -: 8], 1'b0, r);
    endtask

    initial begin
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b0;
        doReset();
        checkOutput("reset_valid", 64'(bus.dout_valid), 64'd0);
        checkOutput("reset_level", 64'(bus.level), 64'd0);
        checkOutput("reset_ovf", 64'(bus.overflow), 64'd0);
        cmpEn = 1'b1;

        // Full word, visible one cycle after the 4th byte
        sendWord(32'h11223344, 1'b1);
        checkOutput("t1_valid", 64'(bus.dout_valid), 64'd1);
        checkOutput("t1_word", 64'(bus.dout), 64'h11223344);
        checkOutput("t1_nbytes", 64'(bus.dout_nbytes), 64'd3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t1_popped", 64'(bus.dout_valid), 64'd0);

        // Flush alone after two bytes
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t2_word", 64'(bus.dout), 64'hAABB0000);
        checkOutput("t2_nbytes", 64'(bus.dout_nbytes), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        sendWord(32'h55667788, 1'b0);
        checkOutput("t2_fresh", 64'(bus.dout), 64'h55667788);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Byte and flush in the same cycle completing a word
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
        checkOutput("t3_word", 64'(bus.dout), 64'h010203CC);
        checkOutput("t3_nbytes", 64'(bus.dout_nbytes), 64'd3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t3_single", 64'(bus.level), 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Continuous stream with toggling ready; wraps the pointers
        for (int i = 0; i < 160; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, i[0]);
            checkOutput("t5_level_le1", 64'(bus.level <= 1), 64'd1);
        end
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_empty", 64'(bus.level), 64'd0);
        checkOutput("t5_no_ovf", 64'(bus.overflow), 64'd0);

        // 17 words with no reader: the 17th is dropped
        for (int w = 0; w < DEPTH + 1; w++) sendWord(32'h1000_0000 + 32'(w), 1'b0);
        checkOutput("t4_level", 64'(bus.level), 64'd16);
        checkOutput("t4_ovf", 64'(bus.overflow), 64'd1);
        checkOutput("t4_head", 64'(bus.dout), 64'h10000000);
        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t4_drained", 64'(bus.level), 64'd0);
        checkOutput("t4_ovf_sticky", 64'(bus.overflow), 64'd1);

        // Asynchronous reset with 3 words stored and 2 bytes held
        doReset();
        for (int w = 0; w < 3; w++) sendWord($urandom, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        bus.din_valid = 1'b0;
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("t6_valid", 64'(bus.dout_valid), 64'd0);
        checkOutput("t6_level", 64'(bus.level), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sendWord(32'hABCDEF01, 1'b0);
        checkOutput("t6_clean", 64'({bus.dout, bus.dout_nbytes}), 64'({32'hABCDEF01, 2'd3}));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic, alternating light and heavy consumer phases
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 7) == 0,
                          (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        end

        cmpEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
